// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master.
// START, addr+rw, ACK, one data byte, ACK/NACK, STOP.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [QW-1:0] q_cnt;
  logic [1:0]    phase;
  logic [3:0]    bit_cnt;
  logic          arm;
  logic          rw_q;
  logic [7:0]    tx_sh;
  logic [7:0]    wd_sh;
  logic [7:0]    rx_sh;
  logic          sda_low;
  logic          scl_d;
  logic          low_d;
  logic          sda_in;
  logic          accept;
  logic          q_tick;
  logic          sample;
  logic          slot_end;
  logic          enter;
  logic          mid;
  logic          finish;

  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign sda_in   = sda;
  assign accept   = (state == IDLE) && start && !busy;
  assign q_tick   = !arm && (state != IDLE)
                 && (q_cnt == Q_LAST);
  assign sample   = q_tick && (phase == 2'd1);
  assign slot_end = q_tick && (phase == 2'd3);
  assign enter    = (state_d != state);
  assign mid      = phase[0] ^ phase[1];
  assign finish   = (state == STOP)
                 && (state_d == IDLE);

  // next-state decode, advancing on quarter ticks
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (accept) state_d = START;
      START:
        if (q_tick && phase == 2'd1)
          state_d = ADDR;
      ADDR:
        if (slot_end && bit_cnt == 4'd0)
          state_d = ACK1;
      ACK1:
        if (slot_end)
          state_d = ack_err ? STOP : DATA;
      DATA:
        if (slot_end && bit_cnt == 4'd0)
          state_d = ACK2;
      ACK2:
        if (slot_end) state_d = STOP;
      STOP:
        if (q_tick && phase == 2'd2)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus levels for the current quarter
  always_comb begin
    scl_d = 1'b1;
    low_d = 1'b0;
    unique case (state)
      IDLE: begin
        scl_d = 1'b1;
        low_d = 1'b0;
      end
      START: begin
        scl_d = (phase == 2'd0);
        low_d = 1'b1;
      end
      ADDR: begin
        scl_d = mid;
        low_d = !tx_sh[7];
      end
      ACK1, ACK2: begin
        scl_d = mid;
        low_d = 1'b0;
      end
      DATA: begin
        scl_d = mid;
        low_d = !rw_q && !wd_sh[7];
      end
      STOP: begin
        scl_d = (phase != 2'd0);
        low_d = (phase != 2'd2);
      end
      default: begin
        scl_d = 1'b1;
        low_d = 1'b0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // quarter counter, slot phase and bit counter;
  // arm holds the counter for one cycle after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt   <= '0;
      phase   <= 2'd0;
      bit_cnt <= 4'd0;
      arm     <= 1'b0;
    end else begin
      arm <= accept;
      if (state == IDLE || arm || q_tick)
        q_cnt <= '0;
      else
        q_cnt <= q_cnt + QW'(1);
      if (accept)
        phase <= 2'd0;
      else if (q_tick)
        phase <= enter ? 2'd0 : phase + 2'd1;
      if (enter && (state_d == ADDR
                 || state_d == DATA))
        bit_cnt <= 4'd7;
      else if (slot_end && (state == ADDR
                         || state == DATA))
        bit_cnt <= bit_cnt - 4'd1;
    end
  end

  // command capture, shift-out and shift-in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q  <= 1'b0;
      tx_sh <= 8'h00;
      wd_sh <= 8'h00;
      rx_sh <= 8'h00;
    end else if (accept) begin
      rw_q  <= rw;
      tx_sh <= {addr, rw};
      wd_sh <= wdata;
    end else begin
      if (slot_end && state == ADDR)
        tx_sh <= {tx_sh[6:0], 1'b0};
      if (slot_end && state == DATA)
        wd_sh <= {wd_sh[6:0], 1'b0};
      if (sample && state == DATA)
        rx_sh <= {rx_sh[6:0], sda_in};
    end
  end

  // host status: busy, done, ack_err, rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      done <= finish;
      if (accept)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      if (accept)
        ack_err <= 1'b0;
      else if (sample && state == ACK1
               && sda_in)
        ack_err <= 1'b1;
      else if (sample && state == ACK2
               && !rw_q && sda_in)
        ack_err <= 1'b1;
      if (slot_end && state == DATA
          && bit_cnt == 4'd0 && rw_q)
        rdata <= rx_sh;
    end
  end

  // registered bus drivers keep SCL/SDA glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl     <= 1'b1;
      sda_low <= 1'b0;
    end else begin
      scl     <= scl_d;
      sda_low <= low_d;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed + random transactions
// against a bus-level target model.
module tb_i2c_master;

  localparam int D = 4;
  localparam logic [6:0] SLV = 7'h57;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = 7'h00;
  logic       rw = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl;
  wire        sda;

  logic       s_low = 1'b0;
  pullup (sda);
  assign sda = s_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .addr   (addr),
    .rw     (rw),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err),
    .scl    (scl),
    .sda    (sda)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [7:0] rd_model = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end

  // target model: ACKs SLV, returns s_tx on read
  logic       s_active = 1'b0;
  int         s_slot = 0;
  logic [7:0] s_sh = 8'h00;
  logic       s_match = 1'b0;
  logic       s_rw = 1'b0;
  logic [7:0] s_tx = 8'h00;
  logic       s_nack = 1'b0;
  logic [7:0] s_din = 8'h00;
  logic       bus_bits[$];

  always @(negedge sda)
    if (scl === 1'b1) begin
      s_active = 1'b1;
      s_slot = 0;
      s_low = 1'b0;
      bus_bits.delete();
    end

  always @(posedge sda)
    if (scl === 1'b1) begin
      s_active = 1'b0;
      s_low = 1'b0;
    end

  always @(posedge scl)
    if (s_active) begin
      bus_bits.push_back(sda);
      if (s_slot < 8) s_sh = {s_sh[6:0], sda};
      if (s_slot == 7) begin
        s_match = (s_sh[7:1] == SLV);
        s_rw = s_sh[0];
      end
      if (s_slot >= 9 && s_slot <= 16
          && s_match && !s_rw)
        s_din = {s_din[6:0], sda};
      s_slot = s_slot + 1;
    end

  always @(negedge scl)
    if (s_active) begin
      s_low = 1'b0;
      if (s_slot == 8)
        s_low = s_match;
      else if (s_slot >= 9 && s_slot <= 16)
        s_low = s_match && s_rw
             && !s_tx[16 - s_slot];
      else if (s_slot == 17)
        s_low = s_match && !s_rw && !s_nack;
    end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [6:0] a,
                         input logic r,
                         input logic [7:0] w,
                         input logic [7:0] tx,
                         input logic nk,
                         input bit poke);
    int n;
    int d0;
    int lat;
    int ne;
    logic match;
    logic exp_err;
    logic [7:0] ab;
    logic [7:0] db;
    logic [31:0] eb;
    logic [31:0] ob;
    match = (a == SLV);
    exp_err = !match || (!r && nk);
    lat = match ? 1 + 77 * D : 1 + 41 * D;
    if (match && r) rd_model = tx;
    s_tx = tx;
    s_nack = nk;
    @(negedge clk); #1;
    addr = a; rw = r; wdata = w; start = 1'b1;
    d0 = done_cnt;
    @(negedge clk); #1;
    start = 1'b0;
    n = cyc;
    chk("busy_on", 32'(busy), 32'd1);
    for (int k = 0; k < 500 && done_cnt == d0; k++) begin
      @(negedge clk); #1;
      if (poke && cyc == n + 100) start = 1'b1;
      if (poke && cyc == n + 101) start = 1'b0;
      if (poke && cyc == n + lat - 1) start = 1'b1;
      if (poke && cyc == n + lat) start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    chk("done_lat", 32'(done_cyc - n), 32'(lat));
    chk("busy_off", 32'(busy), 32'd0);
    chk("ack_err", 32'(ack_err), 32'(exp_err));
    repeat (40) @(negedge clk);
    #1;
    chk("one_done", 32'(done_cnt - d0), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_scl", 32'(scl), 32'd1);
    chk("idle_sda", 32'(sda), 32'd1);
    chk("err_hold", 32'(ack_err), 32'(exp_err));
    chk("rdata", 32'(rdata), 32'(rd_model));
    ab = {a, r};
    eb = '0;
    ne = 0;
    for (int i = 7; i >= 0; i--) begin
      eb = {eb[30:0], ab[i]};
      ne++;
    end
    eb = {eb[30:0], !match};
    ne++;
    if (match) begin
      db = r ? tx : w;
      for (int i = 7; i >= 0; i--) begin
        eb = {eb[30:0], db[i]};
        ne++;
      end
      eb = {eb[30:0], r ? 1'b1 : nk};
      ne++;
    end
    eb = {eb[30:0], 1'b0};
    ne++;
    ob = '0;
    foreach (bus_bits[i]) ob = {ob[30:0], bus_bits[i]};
    chk("nbits", 32'(bus_bits.size()), 32'(ne));
    chk("bits", ob, eb);
    if (match && !r) chk("data_in", 32'(s_din), 32'(w));
  endtask

  initial begin
    int n;
    int d0;
    logic [6:0] ra;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err", 32'(ack_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_txn(7'h57, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0);
    run_txn(7'h57, 1'b1, 8'h00, 8'hDD, 1'b0, 1'b0);
    run_txn(7'h22, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0);
    run_txn(7'h57, 1'b0, 8'($urandom), 8'h00,
            1'b0, 1'b1);

    @(negedge clk); #1;
    addr = 7'h57; rw = 1'b0; wdata = 8'h96;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = cyc;
    d0 = done_cnt;
    while (cyc < n + 219) begin
      @(negedge clk); #1;
    end
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_scl", 32'(scl), 32'd1);
    chk("mid_sda", 32'(sda), 32'd1);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_rdata", 32'(rdata), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_nodone", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    rd_model = 8'h00;
    repeat (2) @(negedge clk);
    run_txn(7'h57, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      ra = ($urandom_range(0, 2) != 0)
         ? SLV : 7'($urandom);
      run_txn(ra, 1'($urandom), 8'($urandom),
              8'($urandom),
              ($urandom_range(0, 3) == 0),
              1'b0);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master that sits directly upstream of the `i2c_slave` target and generates SCL, START/STOP and the bit stream it consumes. On a host command it performs one transaction: START, 7-bit address plus R/W, slave ACK, one data byte (write or read), ACK/NACK, then STOP. It reports completion, returns read data, and flags a missing ACK.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per quarter SCL period (Q). Minimum 2. SCL period is 4·`CLK_DIV` cycles.
- `clk` input 1: system clock. All logic runs on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: command strobe. Accepted on a rising edge only when the registered `busy` is 0.
- `addr` input 7: target address, captured on accept.
- `rw` input 1: 0 = write, 1 = read. Captured on accept.
- `wdata` input 8: write byte, captured on accept.
- `rdata` output 8: read byte. Updated only by a completed read with ACK on the address.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle pulse at the end of a transaction.
- `ack_err` output 1: address NACK, or data NACK on a write. Valid with `done`, held until the next accept.
- `scl` output 1: bus clock, push-pull.
- `sda` inout 1: open-drain. The master only drives 0; otherwise it releases the line to Z. A pull-up is external.

## Operation
- Reset values: `scl`=1, `sda` released, `busy`=0, `done`=0, `rdata`=0, `ack_err`=0, FSM in IDLE.
- Quarter-tick counter counts 0..`CLK_DIV`-1. Each wrap is one Q. Width is $clog2(`CLK_DIV`).
- Bit slot is 4Q:
  - Q0: SCL low; master updates SDA.
  - Q1 and Q2: SCL high.
  - Sample SDA at the Q1→Q2 boundary.
  - Q3: SCL low.
- FSM states:
  - IDLE: SCL=1, SDA released. On accept, capture inputs, set `busy`, clear `ack_err`, go to START.
  - START (2Q): Q0 SCL high, SDA driven low; Q1 SCL low. Go to ADDR.
  - ADDR (8 slots): shift out {addr, rw} MSB first. Driving a 1 means releasing SDA. Go to ACK1.
  - ACK1 (1 slot): release SDA and sample. If sampled 1, set `ack_err` and go to STOP. If sampled 0, go to DATA.
  - DATA (8 slots):
    - Write: shift out `wdata` MSB first.
    - Read: release SDA, shift in MSB first, load `rdata` at the end of the 8th slot.
  - ACK2 (1 slot):
    - Write: release SDA and sample. A 1 sets `ack_err`.
    - Read: release SDA (master NACK, single byte).
    - Then go to STOP.
  - STOP (3Q): Q0 SCL low, SDA low; Q1 SCL high; Q2 SDA released (rise while SCL high). Then pulse `done`, clear `busy`, return to IDLE.
- Bit counter is 4 bits and reloads to 7 at the start of ADDR and of DATA.
- `start` while `busy`=1 is ignored, with no queuing. This includes a `start` at the same edge that pulses `done`, because `busy` is still 1 there.
- Inputs are not re-sampled mid-transaction.
- Reset mid-transaction: immediately `scl`=1, SDA released, `busy`=0, no `done` pulse. `rdata` returns to 0.

## Timing
- Let N be the edge where `start` is accepted. `busy`=1 from N+1.
- Full transaction (address ACKed): 2+36+36+3 = 77Q. `done`=1 for exactly one cycle at edge N+1+77·`CLK_DIV`. `busy` falls on that same edge.
- Address NACK: 2+36+3 = 41Q. `done` at edge N+1+41·`CLK_DIV`.
- SDA changes only while SCL is low, except in START Q0 and STOP Q2.
- The target drives on SCL falling (Q3). Its data is stable before Q1.
- `rdata` is stable before `done` rises.

## Test plan
- Reset: hold `rst_n`=0 → `scl`=1, `sda`=Z (pulled 1), `busy`=0, `done`=0, `rdata`=0x00, `ack_err`=0.
- Write with `addr`=0x57, `rw`=0, `wdata`=0xA5, target attached, `CLK_DIV`=4:
  - SDA bits 1010111 0, ACK 0, 10100101, ACK 0, then STOP.
  - `done` at N+309, `ack_err`=0, target `data_in`=0xA5.
- Read with `addr`=0x57, `rw`=1 → `rdata`=0xDD, master leaves SDA released in ACK2, `ack_err`=0, `done` at N+309.
- Wrong address 0x22 with `rw`=0 → ACK1 samples 1, `ack_err`=1, no DATA slots, STOP issued, `done` at N+165, `rdata` unchanged.
- Overlap: second `start` pulsed mid-transaction and again on the `done` edge → both ignored, exactly one `done`, bus idle afterwards.
- Reset asserted during DATA bit 3 → `scl`=1, SDA released and `busy`=0 immediately, no `done`. A following write of 0x3C to 0x57 completes with `ack_err`=0.
